// File: rtl/ycbcr_coef_pkg.sv
// Shared BT.601 full-range fixed-point (x256) constants for RGB<->YCbCr stages.
// Coefficients are stored as magnitudes; the sign of each term is applied by the consumer.
package ycbcr_coef_pkg;

  localparam logic [7:0]  K_Y_R  = 8'd77;
  localparam logic [7:0]  K_Y_G  = 8'd150;
  localparam logic [7:0]  K_Y_B  = 8'd29;
  localparam logic [7:0]  K_CB_R = 8'd43;
  localparam logic [7:0]  K_CB_G = 8'd85;
  localparam logic [7:0]  K_CB_B = 8'd128;
  localparam logic [7:0]  K_CR_R = 8'd128;
  localparam logic [7:0]  K_CR_G = 8'd107;
  localparam logic [7:0]  K_CR_B = 8'd21;

  localparam logic [17:0] CHROMA_OFFSET = 18'd32768;
  localparam int unsigned N_COEF        = 32'd9;

  // Index order: (Y,Cb,Cr) major, (R,G,B) minor.
  function automatic logic [7:0] coef_mag(input int unsigned idx);
    case (idx)
      32'd0:   return K_Y_R;
      32'd1:   return K_Y_G;
      32'd2:   return K_Y_B;
      32'd3:   return K_CB_R;
      32'd4:   return K_CB_G;
      32'd5:   return K_CB_B;
      32'd6:   return K_CR_R;
      32'd7:   return K_CR_G;
      32'd8:   return K_CR_B;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/mult8x8_reg.sv
// Unsigned 8x8 multiply with a registered 16-bit product.
module mult8x8_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p_q
);

  logic [15:0] p_d;

  // Full-width product of the two unsigned operands.
  always_comb begin
    p_d = {8'd0, a} * {8'd0, b};
  end

  // Product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= 16'd0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/rgb888_ycbcr444.sv
// RGB888 to YCbCr444 converter: 3-stage multiply / sum / saturate pipeline with
// matched vsync/href delays, output line counter and end-of-frame pulse.
module rgb888_ycbcr444
  import ycbcr_coef_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic [7:0]  per_img_red,
  input  logic [7:0]  per_img_green,
  input  logic [7:0]  per_img_blue,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic [7:0]  post_img_Y,
  output logic [7:0]  post_img_Cb,
  output logic [7:0]  post_img_Cr,
  output logic [10:0] post_line_cnt,
  output logic        post_frame_done
);

  // A degenerate frame geometry has no lines to count.
  localparam logic        GEOM_OK   = (IMG_HDISP != 11'd0) && (IMG_VDISP != 11'd0);
  localparam logic [10:0] LAST_LINE = IMG_VDISP - 11'd1;

  logic [7:0]         pix_s [3];
  logic [15:0]        prod_q [N_COEF];
  logic signed [17:0] sum_y_d, sum_cb_d, sum_cr_d;
  logic signed [17:0] sum_y_q, sum_cb_q, sum_cr_q;
  logic [7:0]         y_d, cb_d, cr_d;
  logic [7:0]         y_q, cb_q, cr_q;
  logic [2:0]         href_d, href_q;
  logic [3:0]         vsync_d, vsync_q;
  logic [10:0]        line_cnt_d, line_cnt_q;
  logic               done_d, done_q;

  assign pix_s[0] = per_img_red;
  assign pix_s[1] = per_img_green;
  assign pix_s[2] = per_img_blue;

  for (genvar i = 0; i < N_COEF; i++) begin : g_mult
    mult8x8_reg u_mult (
      .clk (clk),
      .rst (rst),
      .a   (pix_s[i % 3]),
      .b   (coef_mag(i)),
      .p_q (prod_q[i])
    );
  end

  function automatic logic [7:0] sat8(input logic signed [17:0] s);
    logic signed [17:0] sh;
    sh = s >>> 8;
    if (sh < 18'sd0) begin
      return 8'd0;
    end else if (sh > 18'sd255) begin
      return 8'd255;
    end else begin
      return sh[7:0];
    end
  endfunction

  // Signed sums, conversion result gated by the aligned href, and sync/counter next-state.
  always_comb begin
    sum_y_d  = {2'b00, prod_q[0]} + {2'b00, prod_q[1]} + {2'b00, prod_q[2]};
    sum_cb_d = CHROMA_OFFSET + {2'b00, prod_q[5]} - {2'b00, prod_q[3]} - {2'b00, prod_q[4]};
    sum_cr_d = CHROMA_OFFSET + {2'b00, prod_q[6]} - {2'b00, prod_q[7]} - {2'b00, prod_q[8]};

    if (href_q[1]) begin
      y_d  = sat8(sum_y_q);
      cb_d = sat8(sum_cb_q);
      cr_d = sat8(sum_cr_q);
    end else begin
      y_d  = 8'd0;
      cb_d = 8'd0;
      cr_d = 8'd0;
    end

    href_d  = {href_q[1:0], per_frame_href};
    vsync_d = {vsync_q[2:0], per_frame_vsync};

    // href_q[1]/vsync_q[1] are the values post_* take on the coming edge.
    line_cnt_d = line_cnt_q;
    if (!GEOM_OK || !vsync_q[1]) begin
      line_cnt_d = 11'd0;
    end else if (href_q[2] && !href_q[1]) begin
      if (line_cnt_q >= LAST_LINE) begin
        line_cnt_d = 11'd0;
      end else begin
        line_cnt_d = line_cnt_q + 11'd1;
      end
    end else begin
      line_cnt_d = line_cnt_q;
    end

    done_d = vsync_q[3] & ~vsync_q[2];
  end

  // Pipeline, sync-delay and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_y_q    <= 18'sd0;
      sum_cb_q   <= 18'sd0;
      sum_cr_q   <= 18'sd0;
      y_q        <= 8'd0;
      cb_q       <= 8'd0;
      cr_q       <= 8'd0;
      href_q     <= 3'd0;
      vsync_q    <= 4'd0;
      line_cnt_q <= 11'd0;
      done_q     <= 1'b0;
    end else begin
      sum_y_q    <= sum_y_d;
      sum_cb_q   <= sum_cb_d;
      sum_cr_q   <= sum_cr_d;
      y_q        <= y_d;
      cb_q       <= cb_d;
      cr_q       <= cr_d;
      href_q     <= href_d;
      vsync_q    <= vsync_d;
      line_cnt_q <= line_cnt_d;
      done_q     <= done_d;
    end
  end

  assign post_frame_vsync = vsync_q[2];
  assign post_frame_href  = href_q[2];
  assign post_img_Y       = y_q;
  assign post_img_Cb      = cb_q;
  assign post_img_Cr      = cr_q;
  assign post_line_cnt    = line_cnt_q;
  assign post_frame_done  = done_q;

endmodule

// File: tb/tb_rgb888_ycbcr444.sv
// Scoreboard bench for rgb888_ycbcr444: directed colours, a small 4x3 frame
// geometry, mid-line reset and a long random pixel stream.
module tb_rgb888_ycbcr444;

  localparam logic [10:0] H = 11'd4;
  localparam logic [10:0] V = 11'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        per_frame_vsync, per_frame_href;
  logic [7:0]  per_img_red, per_img_green, per_img_blue;
  logic        post_frame_vsync, post_frame_href;
  logic [7:0]  post_img_Y, post_img_Cb, post_img_Cr;
  logic [10:0] post_line_cnt;
  logic        post_frame_done;

  rgb888_ycbcr444 #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk              (clk),
    .rst              (rst),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_img_red      (per_img_red),
    .per_img_green    (per_img_green),
    .per_img_blue     (per_img_blue),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_img_Y       (post_img_Y),
    .post_img_Cb      (post_img_Cb),
    .post_img_Cr      (post_img_Cr),
    .post_line_cnt    (post_line_cnt),
    .post_frame_done  (post_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic [7:0]  y;
    logic [7:0]  cb;
    logic [7:0]  cr;
    logic [10:0] line;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   lines_done = 0;
  int   pix_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    else if (v > 255) return 8'd255;
    else return v[7:0];
  endfunction

  // One clock of stimulus; the expected output for it is queued after the sampling edge.
  task automatic step(input logic rs, input logic vs, input logic hs,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    exp_t e;
    int ri, gi, bi;
    @(negedge clk);
    rst = rs; per_frame_vsync = vs; per_frame_href = hs;
    per_img_red = r; per_img_green = g; per_img_blue = b;
    @(posedge clk);
    e = '0;
    if (rs) begin
      for (int i = 0; i < q.size(); i++) q[i] = '0;
      lines_done = 0;
    end else begin
      ri = int'(r); gi = int'(g); bi = int'(b);
      e.vs   = vs;
      e.hs   = hs;
      e.line = vs ? 11'(lines_done % int'(V)) : 11'd0;
      if (hs) begin
        e.y  = clamp8((77 * ri + 150 * gi + 29 * bi) >>> 8);
        e.cb = clamp8((32768 - 43 * ri - 85 * gi + 128 * bi) >>> 8);
        e.cr = clamp8((32768 + 128 * ri - 107 * gi - 21 * bi) >>> 8);
      end
    end
    q.push_back(e);
  endtask

  // Monitor: every cycle the pipeline presents the output for the input three edges back.
  initial begin
    exp_t e;
    logic h1 = 1'b0;
    logic h2 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b1) begin
        h1 = 1'b0;
        h2 = 1'b0;
      end
      if (q.size() >= 3) begin
        e = q.pop_front();
        chk("vsync", post_frame_vsync, e.vs);
        chk("href", post_frame_href, e.hs);
        chk("Y", post_img_Y, e.y);
        chk("Cb", post_img_Cb, e.cb);
        chk("Cr", post_img_Cr, e.cr);
        chk("line_cnt", post_line_cnt, e.line);
        chk("done", post_frame_done, h2 & ~h1);
        h2 = h1;
        h1 = e.vs;
      end
    end
  end

  task automatic chk_colour(input string name, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [7:0] ey, input logic [7:0] ecb,
                            input logic [7:0] ecr);
    step(1'b0, 1'b1, 1'b1, r, g, b);
    lines_done++;
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    #2;
    chk({name, "_href"}, post_frame_href, 1'b1);
    chk({name, "_Y"}, post_img_Y, ey);
    chk({name, "_Cb"}, post_img_Cb, ecb);
    chk({name, "_Cr"}, post_img_Cr, ecr);
  endtask

  task automatic frame(input int nlines, input int gmin, input int gmax, input bit rnd,
                       input logic [7:0] fr, input logic [7:0] fg, input logic [7:0] fb,
                       input int extra, input bit coincide);
    logic [7:0] r, g, b;
    int gap;
    bit vs_gap;
    lines_done = 0;
    step(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    step(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < int'(H) + extra; p++) begin
        r = rnd ? 8'($urandom) : fr;
        g = rnd ? 8'($urandom) : fg;
        b = rnd ? 8'($urandom) : fb;
        step(1'b0, 1'b1, 1'b1, r, g, b);
        pix_cnt++;
      end
      vs_gap = !(coincide && (l == nlines - 1));
      lines_done = vs_gap ? lines_done + 1 : 0;
      gap = int'($urandom_range(gmax, gmin));
      for (int k = 0; k < gap; k++)
        step(1'b0, vs_gap, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    lines_done = 0;
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    rst = 1'b1; per_frame_vsync = 1'b0; per_frame_href = 1'b0;
    per_img_red = 8'd0; per_img_green = 8'd0; per_img_blue = 8'd0;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    #2;
    chk("rst_vsync", post_frame_vsync, 1'b0);
    chk("rst_href", post_frame_href, 1'b0);
    chk("rst_Y", post_img_Y, 8'd0);
    chk("rst_line", post_line_cnt, 11'd0);
    chk("rst_done", post_frame_done, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    // Directed colours inside one frame of one-pixel lines.
    lines_done = 0;
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    chk_colour("white", 8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128);
    chk_colour("black", 8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128);
    chk_colour("red",   8'd255, 8'd0,   8'd0,   8'd76,  8'd85,  8'd255);
    chk_colour("green", 8'd0,   8'd255, 8'd0,   8'd149, 8'd43,  8'd21);
    chk_colour("blue",  8'd0,   8'd0,   8'd255, 8'd28,  8'd255, 8'd107);
    lines_done = 0;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    // 4x3 frame with 2-cycle gaps, coincident end-of-line/end-of-frame, over-long lines.
    frame(3, 2, 2, 1'b1, 8'd0, 8'd0, 8'd0, 0, 1'b0);
    frame(3, 1, 1, 1'b1, 8'd0, 8'd0, 8'd0, 0, 1'b1);
    frame(3, 1, 2, 1'b1, 8'd0, 8'd0, 8'd0, 6, 1'b0);

    // Reset pulse mid-line with white pixels.
    lines_done = 0;
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
    step(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
    #2;
    chk("midrst_vsync", post_frame_vsync, 1'b0);
    chk("midrst_href", post_frame_href, 1'b0);
    chk("midrst_Y", post_img_Y, 8'd0);
    chk("midrst_Cb", post_img_Cb, 8'd0);
    chk("midrst_Cr", post_img_Cr, 8'd0);
    chk("midrst_line", post_line_cnt, 11'd0);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
    lines_done = 1;
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    lines_done = 0;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    frame(3, 1, 2, 1'b0, 8'd255, 8'd255, 8'd255, 0, 1'b0);

    // Random stream.
    pix_cnt = 0;
    while (pix_cnt < 10000)
      frame(3, 1, 3, 1'b1, 8'd0, 8'd0, 8'd0, ($urandom_range(9, 0) == 0) ? 3 : 0,
            ($urandom_range(7, 0) == 0));

    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb888_ycbcr444.md
RGB888_YCBCR444 -- requirements
Module: rgb888_ycbcr444

Interface
REQ-001 Parameter IMG_HDISP, default 11'd640, active pixels per line.
REQ-002 Parameter IMG_VDISP, default 11'd480, active lines per frame.
REQ-003 clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 per_frame_vsync  input  1  frame-valid from the upstream RAW8-to-RGB888 stage.
REQ-006 per_frame_href  input  1  line-valid; pixel data is valid while high.
REQ-007 per_img_red / per_img_green / per_img_blue  input  8 each  RGB888 pixel.
REQ-008 post_frame_vsync  output  1  per_frame_vsync delayed to align with output data.
REQ-009 post_frame_href  output  1  per_frame_href delayed to align with output data.
REQ-010 post_img_Y / post_img_Cb / post_img_Cr  output  8 each  YCbCr444 pixel.
REQ-011 post_line_cnt  output  11  index of the line currently output (0..IMG_VDISP-1).
REQ-012 post_frame_done  output  1  one-cycle pulse on the falling edge of post_frame_vsync.

Function
REQ-013 Conversion SHALL be BT.601 full-range fixed point (x256): Y=(77R+150G+29B)>>8; Cb=(-43R-85G+128B+32768)>>8; Cr=(128R-107G-21B+32768)>>8.
REQ-014 Pipeline SHALL have 3 stages: S1 registers the nine 8x8 unsigned products (16 bits each); S2 registers the three signed sums including the 32768 offset (18-bit signed); S3 registers the >>8 result, saturated to 0..255.
REQ-015 Latency from an input pixel to its output pixel SHALL be exactly 3 clk cycles.
REQ-016 The data pipeline SHALL advance every cycle, regardless of href; there is no stall or backpressure.
REQ-017 post_frame_vsync and post_frame_href SHALL be 3-cycle shift-register delays of the inputs, matched to REQ-015.
REQ-018 When post_frame_href is 0, post_img_Y/Cb/Cr SHALL output 0.
REQ-019 The >>8 shift SHALL truncate (floor); saturation SHALL clamp negative results to 0 and results above 255 to 255.
REQ-020 post_line_cnt SHALL increment on each falling edge of post_frame_href while post_frame_vsync=1.
REQ-021 post_line_cnt SHALL wrap to 0 after IMG_VDISP-1.
REQ-022 post_line_cnt SHALL clear to 0 while post_frame_vsync=0.
REQ-023 post_frame_done SHALL assert for exactly one cycle, on the cycle after post_frame_vsync goes from 1 to 0.
REQ-024 If the href falling edge and the vsync falling edge coincide, the vsync clear SHALL win: line_cnt=0, and done is still pulsed.
REQ-025 Back-to-back lines with a single-cycle href gap SHALL each be counted.
REQ-026 Href held high for longer than IMG_HDISP cycles SHALL NOT affect the conversion (no pixel counter gating).

Reset
REQ-027 While rst=1 at a clk edge, all pipeline, sync-delay and counter registers SHALL clear to 0.
REQ-028 Reset outputs SHALL be: post_frame_vsync=0, post_frame_href=0, Y/Cb/Cr=0, post_line_cnt=0, post_frame_done=0.
REQ-029 Reset asserted mid-frame SHALL discard the in-flight pixels.
REQ-030 After rst deasserts, output SHALL resume 3 cycles after the next valid input, with no spurious done pulse.

Structure
REQ-031 The nine coefficients and the 32768 offset SHALL be constants in the shared image-processing package (ycbcr_coef_pkg), reusable by a YCbCr-to-RGB stage.
REQ-032 The 8x8 multiply plus register SHALL be one sub-module, mult8x8_reg, instantiated nine times.
REQ-033 Saturation SHALL be inline in rgb888_ycbcr444.

Verification
REQ-034 R=G=B=255 with href=1 -> after 3 cycles Y=255, Cb=128, Cr=128.
REQ-035 R=G=B=0 -> Y=0, Cb=128, Cr=128.
REQ-036 Pure red (255,0,0) -> Y=76, Cb=85, Cr=255; pure green (0,255,0) -> Y=149, Cb=43, Cr=21; pure blue (0,0,255) -> Y=28, Cb=255, Cr=107.
REQ-037 4x3 frame (IMG_HDISP=4, IMG_VDISP=3) with 2-cycle href gaps -> post_line_cnt reads 0,1,2 during the lines, post_frame_done is a single pulse 1 cycle after post vsync falls, and href/vsync are delayed exactly 3 cycles.
REQ-038 rst pulsed for 1 cycle mid-line with white pixels -> next cycle all outputs are 0, no done pulse follows, and the next frame converts correctly.
REQ-039 Random RGB stream of 10000 pixels compared against a golden model of REQ-013/019 -> zero mismatches, with output Y/Cb/Cr=0 whenever post href=0.
